// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: queues scan-code bytes and sends them as 11-bit device-clocked frames.
// Latency: a byte written into an empty, idle block drives its start bit two cycles after the write.
// Backpressure: full is asserted at 8 queued bytes; writes while full are dropped and latch overflow.
//
// Ports:
//   clk, clrn          - clock (rising edge) and synchronous active-low reset
//   wr_en, wr_data     - push a scan-code byte into the 8-entry TX FIFO
//   full, busy         - FIFO full; frame or inter-frame gap in progress
//   overflow           - sticky flag, set when a write was dropped
//   ps2_clk, ps2_data  - registered PS/2 clock and data lines
module ps2_kbd_tx #(
  parameter int CLK_DIV = 4,  // clk cycles per ps2_clk half-period
  parameter int GAP     = 8   // idle-high clk cycles between frames
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_GAP} state_t;

  state_t        state;
  logic [7:0]    mem [8];
  logic [2:0]    wr_ptr;
  logic [2:0]    rd_ptr;
  logic [3:0]    count;
  logic [3:0]    count_nxt;
  logic          push;
  logic          pop;
  logic          gap_done;
  logic [7:0]    head;
  logic [10:0]   frame;
  logic [3:0]    bit_idx;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;

  // The last gap cycle doubles as the idle decision point, so back-to-back
  // frames are separated by exactly GAP idle-high cycles.
  always_comb begin
    head      = mem[rd_ptr];
    gap_done  = (state == ST_GAP) && (gap_cnt == GAP_LAST);
    push      = wr_en && !full;
    pop       = ((state == ST_IDLE) || gap_done) && (count != 4'd0);
    count_nxt = count + {3'b000, push} - {3'b000, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // full uses the registered value, so a write while full is dropped even
  // when a pop frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      count    <= 4'd0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
      count <= count_nxt;
      full  <= (count_nxt == 4'd8);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Data only changes together with the rising ps2_clk edge (first HIGH
  // cycle), so it is stable for the whole low half-period.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state    <= ST_IDLE;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
      frame    <= '0;
      bit_idx  <= 4'd0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if ((state == ST_GAP) && !gap_done) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else if (pop) begin
            // {stop, odd parity, data, start}
            frame    <= {1'b1, ~^head, head, 1'b0};
            bit_idx  <= 4'd0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            ps2_data <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_HIGH;
          end else begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            ps2_clk <= 1'b0;
            state   <= ST_LOW;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_LOW: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            ps2_clk <= 1'b1;
            if (bit_idx == 4'd10) begin
              ps2_data <= 1'b1;
              gap_cnt  <= '0;
              state    <= ST_GAP;
            end else begin
              bit_idx  <= bit_idx + 4'd1;
              ps2_data <= frame[bit_idx + 4'd1];
              state    <= ST_HIGH;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Testbench for ps2_kbd_tx: a line monitor decodes frames at ps2_clk falling
// edges and each scenario task compares against an arithmetic frame model.
module tb_ps2_kbd_tx;

  localparam int CLK_DIV   = 4;
  localparam int GAP       = 8;
  localparam int FRAME_CYC = 22 * CLK_DIV;

  logic       clk      = 1'b0;
  logic       clrn     = 1'b0;
  logic       wr_en    = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       full;
  logic       busy;
  logic       overflow;
  logic       ps2_clk;
  logic       ps2_data;

  int tests = 0;
  int fails = 0;

  ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .busy    (busy),
    .overflow(overflow),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data)
  );

  always #5 clk = ~clk;

  // Line monitor, sampled mid-cycle.
  logic        prev_clk  = 1'b1;
  logic        prev_data = 1'b1;
  int          nfall     = 0;
  int          viol      = 0;
  int          run       = 0;
  int          bitcnt    = 0;
  logic [10:0] shreg     = '0;
  logic [10:0] frames[$];
  int          runs[$];

  always @(negedge clk) begin
    if (clrn !== 1'b1) begin
      bitcnt = 0;
      run    = 0;
    end else begin
      if (ps2_clk === 1'b0 && ps2_data !== prev_data) viol++;
      if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
        nfall++;
        shreg[bitcnt] = ps2_data;
        bitcnt++;
        if (bitcnt == 11) begin
          frames.push_back(shreg);
          bitcnt = 0;
        end
      end
      if (ps2_clk === 1'b1 && ps2_data === 1'b1) begin
        run++;
      end else begin
        if (ps2_clk === 1'b1 && ps2_data === 1'b0 && prev_clk === 1'b1 &&
            prev_data === 1'b1 && bitcnt == 0)
          runs.push_back(run);
        run = 0;
      end
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line values in transmission order: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_idle(input int budget, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (busy === 1'b0) quiet++;
      else quiet = 0;
      if (quiet >= 4) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0; wr_en = 1'b1; wr_data = 8'hA5;
    repeat (3) tick();
    wr_en = 1'b0; clrn = 1'b1;
    tick();
    tests++; if (ps2_clk !== 1'b1) begin fails++; $display("FAIL reset_ps2_clk: got %b want 1", ps2_clk); end
    tests++; if (ps2_data !== 1'b1) begin fails++; $display("FAIL reset_ps2_data: got %b want 1", ps2_data); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    repeat (10) tick();
    tests++; if (busy !== 1'b0 || nfall != 0) begin fails++; $display("FAIL reset_quiet: busy %b falls %0d want 0 0", busy, nfall); end
  endtask

  task automatic test_single();
    int f0;
    frames.delete();
    f0 = nfall;
    wr_en = 1'b1; wr_data = 8'h1C;          // cycle 0
    tick(); wr_en = 1'b0;                   // cycle 1
    tests++; if (ps2_data !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL single_cycle1: data %b busy %b want 1 0", ps2_data, busy); end
    tick();                                 // cycle 2
    tests++; if (ps2_data !== 1'b0 || ps2_clk !== 1'b1) begin fails++; $display("FAIL single_start_latency: data %b clk %b want 0 1", ps2_data, ps2_clk); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_start: got %b want 1", busy); end
    repeat (FRAME_CYC + GAP - 1) tick();   // last gap cycle
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_last_gap: got %b want 1", busy); end
    tick();                                 // frame start + 96
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_drop: got %b want 0", busy); end
    tests++; if (nfall - f0 != 11) begin fails++; $display("FAIL single_fall_count: got %0d want 11", nfall - f0); end
    tests++; if (frames.size() != 1) begin fails++; $display("FAIL single_frame_count: got %0d want 1", frames.size()); end
    if (frames.size() >= 1) begin
      tests++; if (frames[0] !== 11'b100_0011_1000) begin fails++; $display("FAIL single_bits: got %b want 10000111000", frames[0]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    frames.delete();
    runs.delete();
    wr_en = 1'b1; wr_data = 8'hF0;
    tick(); wr_data = 8'h1C;
    tick(); wr_en = 1'b0;
    wait_idle(3 * (FRAME_CYC + GAP), ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout: busy never dropped"); end
    tests++; if (frames.size() != 2) begin fails++; $display("FAIL b2b_frame_count: got %0d want 2", frames.size()); end
    if (frames.size() >= 2) begin
      tests++; if (frames[0] !== model_frame(8'hF0)) begin fails++; $display("FAIL b2b_frame1: got %b want %b", frames[0], model_frame(8'hF0)); end
      tests++; if (frames[0][9] !== 1'b1) begin fails++; $display("FAIL b2b_parity1: got %b want 1", frames[0][9]); end
      tests++; if (frames[1] !== model_frame(8'h1C)) begin fails++; $display("FAIL b2b_frame2: got %b want %b", frames[1], model_frame(8'h1C)); end
      tests++; if (frames[1][9] !== 1'b0) begin fails++; $display("FAIL b2b_parity2: got %b want 0", frames[1][9]); end
    end
    tests++; if (runs.size() != 2) begin fails++; $display("FAIL b2b_start_count: got %0d want 2", runs.size()); end
    if (runs.size() >= 2) begin
      tests++; if (runs[1] != GAP) begin fails++; $display("FAIL b2b_gap_len: got %0d want %0d", runs[1], GAP); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    logic [7:0] b;
    bit ok;
    frames.delete();
    for (int c = 0; c < 10; c++) begin
      b = 8'($urandom);
      wr_en = 1'b1; wr_data = b;
      if (c < 9) exp.push_back(b);
      if (c == 8) begin
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL ovf_full_early: got %b want 0", full); end
      end
      if (c == 9) begin
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full_set: got %b want 1", full); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_flag_early: got %b want 0", overflow); end
      end
      tick();
    end
    wr_en = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag_set: got %b want 1", overflow); end
    wait_idle(10 * (FRAME_CYC + GAP) + 100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovf_timeout: busy never dropped"); end
    tests++; if (frames.size() != 9) begin fails++; $display("FAIL ovf_frame_count: got %0d want 9", frames.size()); end
    for (int i = 0; i < 9 && i < frames.size(); i++) begin
      tests++; if (frames[i] !== model_frame(exp[i])) begin fails++; $display("FAIL ovf_frame%0d: got %b want %b", i, frames[i], model_frame(exp[i])); end
    end
    tests++; if (overflow !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL ovf_sticky: overflow %b full %b want 1 0", overflow, full); end
  endtask

  task automatic test_reset_midframe();
    int f0;
    frames.delete();
    f0 = nfall;
    wr_en = 1'b1; wr_data = 8'h5A;
    tick(); wr_data = 8'h33;
    tick(); wr_en = 1'b0;                   // first HIGH cycle of frame
    repeat (2 * CLK_DIV * 5 + CLK_DIV + 1) tick();   // inside LOW of bit 5
    tests++; if (ps2_clk !== 1'b0 || nfall - f0 != 6) begin fails++; $display("FAIL mid_position: clk %b falls %0d want 0 6", ps2_clk, nfall - f0); end
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    tests++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin fails++; $display("FAIL mid_lines: clk %b data %b want 1 1", ps2_clk, ps2_data); end
    tests++; if (full !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_flags: full %b ovf %b busy %b want 0 0 0", full, overflow, busy); end
    f0 = nfall;
    repeat (3 * (FRAME_CYC + GAP)) tick();
    tests++; if (nfall != f0 || busy !== 1'b0 || frames.size() != 0) begin fails++; $display("FAIL mid_quiet: falls %0d busy %b frames %0d want 0 0 0", nfall - f0, busy, frames.size()); end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    logic [7:0] b;
    int written;
    int guard;
    bit ok;
    frames.delete();
    written = 0;
    for (int n = 0; n < 40; n++) begin
      guard = 0;
      while ((written - frames.size()) > 6 && guard < 2000) begin
        tick();
        guard++;
      end
      tests++; if (guard >= 2000) begin fails++; $display("FAIL rnd_throttle_timeout: byte %0d outstanding %0d", n, written - frames.size()); end
      b = 8'($urandom);
      wr_en = 1'b1; wr_data = b;
      exp.push_back(b);
      written++;
      tick();
      wr_en = 1'b0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(20, 200)) tick();
      else repeat ($urandom_range(0, 4)) tick();
    end
    wait_idle(8 * (FRAME_CYC + GAP) + 100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rnd_timeout: busy never dropped"); end
    tests++; if (frames.size() != exp.size()) begin fails++; $display("FAIL rnd_frame_count: got %0d want %0d", frames.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < frames.size(); i++) begin
      tests++; if (frames[i] !== model_frame(exp[i])) begin fails++; $display("FAIL rnd_frame%0d: got %b want %b", i, frames[i], model_frame(exp[i])); end
    end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rnd_overflow: got %b want 0", overflow); end
    tests++; if (viol != 0) begin fails++; $display("FAIL data_change_while_clk_low: got %0d want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per ps2_clk half-period (legal >= 2).
REQ-002 SHALL have parameter GAP, default 8, meaning idle clk cycles inserted between consecutive frames (legal >= 1).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port clrn  input  1  synchronous active-low reset.
REQ-005 SHALL have port wr_en  input  1  push wr_data into the TX FIFO this cycle.
REQ-006 SHALL have port wr_data  input  8  scan-code byte to send.
REQ-007 SHALL have port full  output  1  FIFO holds 8 entries.
REQ-008 SHALL have port busy  output  1  a frame or the inter-frame gap is in progress.
REQ-009 SHALL have port overflow  output  1  sticky; a write was dropped.
REQ-010 SHALL have port ps2_clk  output  1  device-generated PS/2 clock, registered.
REQ-011 SHALL have port ps2_data  output  1  device-generated PS/2 data, registered.

Function
REQ-012 SHALL buffer bytes in an 8-entry FIFO with 3-bit wrapping read/write pointers and a 4-bit occupancy count (0..8).
REQ-013 SHALL accept a write when wr_en=1 and full=0; full is the registered pre-edge value, so a write while full is dropped even if a pop occurs in the same cycle.
REQ-014 SHALL set overflow=1 on any dropped write and hold it until reset.
REQ-015 SHALL use states IDLE, HIGH, LOW, GAP; full/busy/overflow/ps2_* all registered.
REQ-016 IDLE: ps2_clk=1, ps2_data=1, busy=0; if count!=0, pop head, load 11-bit frame {stop=1, parity, data[7:0], start=0}, bit index=0, go HIGH.
REQ-017 Parity SHALL be odd: parity = ~^data, so data plus parity has an odd number of ones.
REQ-018 HIGH: ps2_clk=1, ps2_data=frame bit[index] from the first HIGH cycle; after CLK_DIV cycles go LOW.
REQ-019 LOW: ps2_clk=0, ps2_data unchanged; after CLK_DIV cycles, if index=10 go GAP, else index+1 and go HIGH.
REQ-020 Data SHALL change only in the first cycle of HIGH, never while ps2_clk=0 and never in the same cycle as a ps2_clk falling edge.
REQ-021 Bits SHALL be sent start, data LSB first, parity, stop; 11 falling ps2_clk edges per frame.
REQ-022 Frame length SHALL be 22*CLK_DIV cycles from the first HIGH cycle to the end of the last LOW cycle.
REQ-023 GAP: ps2_clk=1, ps2_data=1 for GAP cycles, then IDLE (next pop on the following edge if non-empty).
REQ-024 busy SHALL be 1 in HIGH, LOW and GAP, and 0 in IDLE.
REQ-025 Latency: wr_en at cycle 0 into an empty idle block SHALL give ps2_data=0 (start bit) visible at cycle 2.
REQ-026 A FIFO write and pop in the same cycle SHALL leave count unchanged and keep pointer wrap-around correct.
REQ-027 Writes during a frame SHALL NOT disturb the frame in progress.

Reset
REQ-028 clrn=0 at a rising edge SHALL set state=IDLE, pointers=0, count=0, full=0, busy=0, overflow=0, ps2_clk=1, ps2_data=1, discarding any frame and all queued bytes.
REQ-029 Reset mid-frame SHALL leave ps2_clk=1 and ps2_data=1 from the next cycle, with no further falling edge.

Verification
REQ-030 Write 0x1C -> values sampled at the 11 ps2_clk falling edges = 0,0,0,1,1,1,0,0,0,0,1; ps2_data=0 at cycle 2; busy drops 88+8 cycles after the frame starts (CLK_DIV=4, GAP=8).
REQ-031 Write 0xF0 then 0x1C back-to-back -> frame 1 parity bit=1, frame 2 parity=0; exactly 8 idle-high cycles between the last LOW of frame 1 and the start bit of frame 2.
REQ-032 Write 10 bytes on cycles 0..9 from idle -> full=1 after the cycle-8 write; byte 10 dropped; overflow=1; exactly 9 frames are sent.
REQ-033 Pulse clrn=0 during the LOW phase of bit 5 -> next cycle ps2_clk=1, ps2_data=1, full=0, overflow=0, busy=0; no further edges.
REQ-034 Loopback: connect ps2_clk/ps2_data to the team's ps2_keyboard receiver on the same clk; send 0x1C,0xF0,0x1C -> receiver ready rises and it yields 0x1C,0xF0,0x1C in order with overflow=0.
REQ-035 Random check: pseudo-random writes and throttling -> every accepted byte is sent once, in order, with correct parity, and ps2_data never changes while ps2_clk=0.
